// File: rtl/video_vga_rx_pkg.sv
// -----------------------------------------------------------------------------
// video_vga_rx_pkg
// Shared 640x480@60 timing constants (common to the VGA transmitter and
// receiver) and the receiver lock FSM state encoding.
// No ports: imported with "import video_vga_rx_pkg::*;".
// -----------------------------------------------------------------------------
package video_vga_rx_pkg;

   // Default 640x480@60 timing, in pixel clocks (horizontal) and lines (vertical)
   localparam int VGA_H_ACTIVE     = 640;
   localparam int VGA_H_BACK_PORCH = 48;
   localparam int VGA_H_TOTAL      = 800;
   localparam int VGA_V_ACTIVE     = 480;
   localparam int VGA_V_START      = 32;
   localparam int VGA_V_TOTAL      = 525;

   // Width of position counters and measurement outputs
   localparam int VGA_CW           = 11;

   // Receiver lock state machine
   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/video_vga_rx_sync_meas.sv
// -----------------------------------------------------------------------------
// vga_rx_sync_meas
// Input register stage, sync edge detection, horizontal/vertical position
// counters, line watchdog and line/frame period measurement for the VGA
// receiver.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   i_hsync, i_vsync    raw sync inputs (active low)
//   i_rgb               raw {r,g,b} input
//   o_rgb               stage-1 registered {r,g,b}
//   o_hpos, o_vpos      position of the current stage-1 sample
//   o_h_meas_vld        a new line period is available this cycle (o_h_meas)
//   o_vpos_rst          vpos is reset to 0 on this sample
//   o_v_meas_vld        a new frame length is available this cycle (o_v_meas)
//   o_timeout           2*H_TOTAL samples without an h-rise
//   o_h_total_meas      last measured line period (registered)
//   o_v_total_meas      last measured frame length (registered)
// -----------------------------------------------------------------------------
module vga_rx_sync_meas
   import video_vga_rx_pkg::*;
#(
   parameter int H_TOTAL = VGA_H_TOTAL,
   parameter int CW      = VGA_CW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_hsync,
   input  logic          i_vsync,
   input  logic [11:0]   i_rgb,
   output logic [11:0]   o_rgb,
   output logic [CW-1:0] o_hpos,
   output logic [CW-1:0] o_vpos,
   output logic          o_h_meas_vld,
   output logic [CW-1:0] o_h_meas,
   output logic          o_vpos_rst,
   output logic          o_v_meas_vld,
   output logic [CW-1:0] o_v_meas,
   output logic          o_timeout,
   output logic [CW-1:0] o_h_total_meas,
   output logic [CW-1:0] o_v_total_meas
);

   localparam logic [CW-1:0] C_MAX      = '1;
   localparam int            WDW        = $clog2(2 * H_TOTAL + 1);
   localparam logic [WDW-1:0] C_WD_LIMIT = WDW'(2 * H_TOTAL);

   // Stage-1 samples and their previous values for edge detection
   logic           r_hs;
   logic           r_vs;
   logic           r_hs_d;
   logic           r_vs_d;
   logic [11:0]    r_rgb;

   logic           r_h_seen;     // at least one h-rise since reset
   logic           r_v_arm;      // v-rise seen, waiting for the next h-rise
   logic           r_vrst_seen;  // at least one vpos reset since reset
   logic [CW-1:0]  r_hpos;
   logic [CW-1:0]  r_vpos;
   logic [WDW-1:0] r_wd;
   logic [CW-1:0]  r_h_total_meas;
   logic [CW-1:0]  r_v_total_meas;

   logic           w_h_rise;
   logic           w_v_rise;
   logic           w_vpos_rst;
   logic           w_h_meas_vld;
   logic           w_v_meas_vld;
   logic [CW-1:0]  w_h_len;
   logic [CW-1:0]  w_v_len;
   logic [CW-1:0]  w_hpos;
   logic [CW-1:0]  w_vpos;
   logic [WDW-1:0] w_wd;

   assign w_h_rise   = r_hs & ~r_hs_d;
   assign w_v_rise   = r_vs & ~r_vs_d;
   // A v-rise arms the vertical reset; a coincident v-rise counts as armed
   assign w_vpos_rst = w_h_rise & (r_v_arm | w_v_rise);

   // Saturating "previous position + 1": the length of the line / frame that
   // ends at this h-rise. Saturation keeps a lost sync from wrapping back
   // into the active window.
   assign w_h_len = (r_hpos == C_MAX) ? C_MAX : r_hpos + 1'b1;
   assign w_v_len = (r_vpos == C_MAX) ? C_MAX : r_vpos + 1'b1;

   // Positions are combinational so they line up with the stage-1 sample
   // that causes the edge (the h-rise sample itself is hpos 0).
   assign w_hpos = w_h_rise ? '0 : w_h_len;

   always_comb begin
      w_vpos = r_vpos;
      if (w_vpos_rst)
         w_vpos = '0;
      else if (w_h_rise)
         w_vpos = w_v_len;
   end

   assign w_wd = w_h_rise ? '0 : ((r_wd == C_WD_LIMIT) ? r_wd : r_wd + 1'b1);

   assign w_h_meas_vld = w_h_rise & r_h_seen;
   assign w_v_meas_vld = w_vpos_rst & r_vrst_seen;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs           <= 1'b1;
         r_vs           <= 1'b1;
         r_hs_d         <= 1'b1;
         r_vs_d         <= 1'b1;
         r_rgb          <= '0;
         r_h_seen       <= 1'b0;
         r_v_arm        <= 1'b0;
         r_vrst_seen    <= 1'b0;
         r_hpos         <= '0;
         r_vpos         <= '0;
         r_wd           <= '0;
         r_h_total_meas <= '0;
         r_v_total_meas <= '0;
      end else begin
         r_hs   <= i_hsync;
         r_vs   <= i_vsync;
         r_rgb  <= i_rgb;
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
         r_hpos <= w_hpos;
         r_vpos <= w_vpos;
         r_wd   <= w_wd;

         if (w_h_rise)
            r_h_seen <= 1'b1;
         if (w_h_meas_vld)
            r_h_total_meas <= w_h_len;

         if (w_vpos_rst) begin
            r_v_arm     <= 1'b0;
            r_vrst_seen <= 1'b1;
            if (r_vrst_seen)
               r_v_total_meas <= w_v_len;
         end else if (w_v_rise) begin
            r_v_arm <= 1'b1;
         end
      end
   end

   assign o_rgb          = r_rgb;
   assign o_hpos         = w_hpos;
   assign o_vpos         = w_vpos;
   assign o_h_meas_vld   = w_h_meas_vld;
   assign o_h_meas       = w_h_len;
   assign o_vpos_rst     = w_vpos_rst;
   assign o_v_meas_vld   = w_v_meas_vld;
   assign o_v_meas       = w_v_len;
   assign o_timeout      = (w_wd == C_WD_LIMIT);
   assign o_h_total_meas = r_h_total_meas;
   assign o_v_total_meas = r_v_total_meas;

endmodule

// File: rtl/video_vga_rx.sv
// -----------------------------------------------------------------------------
// video_vga_rx
// VGA capture front end: measures line/frame timing of an incoming RGB444 +
// hsync/vsync stream, locks when it matches the configured mode and emits
// active pixels with x/y coordinates (2 clk latency from the input pins).
//
// Ports:
//   clk, rst                   pixel clock, asynchronous active-high reset
//   vga_r/g/b                  4-bit colour inputs
//   vga_hsync, vga_vsync       sync inputs, active low
//   locked                     timing lock indicator
//   pixel_valid/x/y/rgb        active pixel stream
//   line_start, frame_start    pulses with x==0 / (0,0) of valid pixels
//   h_total_meas, v_total_meas last measured line period / frame length
//   lock_err_cnt               saturating count of lock losses
// -----------------------------------------------------------------------------
module video_vga_rx
   import video_vga_rx_pkg::*;
#(
   parameter int H_ACTIVE     = VGA_H_ACTIVE,
   parameter int H_BACK_PORCH = VGA_H_BACK_PORCH,
   parameter int H_TOTAL      = VGA_H_TOTAL,
   parameter int V_ACTIVE     = VGA_V_ACTIVE,
   parameter int V_START      = VGA_V_START,
   parameter int V_TOTAL      = VGA_V_TOTAL,
   parameter int CW           = VGA_CW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    vga_r,
   input  logic [3:0]    vga_g,
   input  logic [3:0]    vga_b,
   input  logic          vga_hsync,
   input  logic          vga_vsync,
   output logic          locked,
   output logic          pixel_valid,
   output logic [9:0]    pixel_x,
   output logic [9:0]    pixel_y,
   output logic [11:0]   pixel_rgb,
   output logic          line_start,
   output logic          frame_start,
   output logic [CW-1:0] h_total_meas,
   output logic [CW-1:0] v_total_meas,
   output logic [7:0]    lock_err_cnt
);

   localparam logic [CW-1:0] C_H_TOTAL = CW'(H_TOTAL);
   localparam logic [CW-1:0] C_V_TOTAL = CW'(V_TOTAL);
   localparam logic [CW-1:0] C_H_BEG   = CW'(H_BACK_PORCH);
   localparam logic [CW-1:0] C_H_END   = CW'(H_BACK_PORCH + H_ACTIVE);
   localparam logic [CW-1:0] C_V_BEG   = CW'(V_START);
   localparam logic [CW-1:0] C_V_END   = CW'(V_START + V_ACTIVE);

   logic [11:0]   w_rgb1;
   logic [CW-1:0] w_hpos;
   logic [CW-1:0] w_vpos;
   logic          w_h_meas_vld;
   logic [CW-1:0] w_h_meas;
   logic          w_vpos_rst;
   logic          w_v_meas_vld;
   logic [CW-1:0] w_v_meas;
   logic          w_timeout;
   logic          w_line_bad;
   logic          w_frame_bad;
   logic          w_active;
   logic          w_emit;
   logic [9:0]    w_x;
   logic [9:0]    w_y;

   rx_state_t     r_state;
   logic          r_line_err;
   logic          r_locked;
   logic [7:0]    r_lock_err_cnt;
   logic          r_pixel_valid;
   logic [9:0]    r_pixel_x;
   logic [9:0]    r_pixel_y;
   logic [11:0]   r_pixel_rgb;
   logic          r_line_start;
   logic          r_frame_start;

   vga_rx_sync_meas #(
      .H_TOTAL (H_TOTAL),
      .CW      (CW)
   ) u_sync_meas (
      .clk            (clk),
      .rst            (rst),
      .i_hsync        (vga_hsync),
      .i_vsync        (vga_vsync),
      .i_rgb          ({vga_r, vga_g, vga_b}),
      .o_rgb          (w_rgb1),
      .o_hpos         (w_hpos),
      .o_vpos         (w_vpos),
      .o_h_meas_vld   (w_h_meas_vld),
      .o_h_meas       (w_h_meas),
      .o_vpos_rst     (w_vpos_rst),
      .o_v_meas_vld   (w_v_meas_vld),
      .o_v_meas       (w_v_meas),
      .o_timeout      (w_timeout),
      .o_h_total_meas (h_total_meas),
      .o_v_total_meas (v_total_meas)
   );

   assign w_line_bad  = w_h_meas_vld & (w_h_meas != C_H_TOTAL);
   assign w_frame_bad = w_v_meas_vld & (w_v_meas != C_V_TOTAL);

   // Lock FSM. The line-error flag collects bad line periods across one
   // measured frame; the line ending on the vpos-reset sample is included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_SEARCH;
         r_line_err     <= 1'b0;
         r_locked       <= 1'b0;
         r_lock_err_cnt <= '0;
      end else begin
         case (r_state)
            ST_SEARCH: begin
               if (w_vpos_rst) begin
                  r_state    <= ST_MEASURE;
                  r_line_err <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (w_timeout) begin
                  r_state <= ST_SEARCH;
               end else if (w_vpos_rst) begin
                  if (!(r_line_err | w_line_bad) && w_v_meas_vld &&
                      (w_v_meas == C_V_TOTAL)) begin
                     r_state  <= ST_LOCKED;
                     r_locked <= 1'b1;
                  end
                  r_line_err <= 1'b0;
               end else if (w_line_bad) begin
                  r_line_err <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_timeout | w_line_bad | w_frame_bad) begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
                  if (r_lock_err_cnt != 8'hFF)
                     r_lock_err_cnt <= r_lock_err_cnt + 8'd1;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   // Active window test on the stage-1 sample position
   assign w_active = (w_hpos >= C_H_BEG) && (w_hpos < C_H_END) &&
                     (w_vpos >= C_V_BEG) && (w_vpos < C_V_END);
   assign w_emit   = w_active & r_locked;
   assign w_x      = 10'(w_hpos - C_H_BEG);
   assign w_y      = 10'(w_vpos - C_V_BEG);

   // Output stage: coordinates hold while idle, colour is blanked to 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pixel_valid <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_pixel_rgb   <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pixel_valid <= w_emit;
         r_line_start  <= w_emit & (w_x == 10'd0);
         r_frame_start <= w_emit & (w_x == 10'd0) & (w_y == 10'd0);
         if (w_emit) begin
            r_pixel_x   <= w_x;
            r_pixel_y   <= w_y;
            r_pixel_rgb <= w_rgb1;
         end else begin
            r_pixel_rgb <= '0;
         end
      end
   end

   assign locked       = r_locked;
   assign lock_err_cnt = r_lock_err_cnt;
   assign pixel_valid  = r_pixel_valid;
   assign pixel_x      = r_pixel_x;
   assign pixel_y      = r_pixel_y;
   assign pixel_rgb    = r_pixel_rgb;
   assign line_start   = r_line_start;
   assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_video_vga_rx.sv
// -----------------------------------------------------------------------------
// tb_video_vga_rx
// Directed self-checking bench for video_vga_rx using a reduced video mode
// (16 clk lines, 10 line frames). Each bench line starts with 2 clk of hsync
// low, so hpos = cycle-2; the last line of a frame carries vsync low, so the
// bench line index equals vpos. Sample colour is {line[5:0], cycle[5:0]}.
// -----------------------------------------------------------------------------
module tb_video_vga_rx;

   localparam int HA  = 8;
   localparam int HBP = 3;
   localparam int HT  = 16;
   localparam int VA  = 4;
   localparam int VS  = 2;
   localparam int VT  = 10;
   localparam int CW  = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    vga_r, vga_g, vga_b;
   logic          vga_hsync, vga_vsync;
   logic          locked, pixel_valid, line_start, frame_start;
   logic [9:0]    pixel_x, pixel_y;
   logic [11:0]   pixel_rgb;
   logic [CW-1:0] h_total_meas, v_total_meas;
   logic [7:0]    lock_err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   video_vga_rx #(
      .H_ACTIVE(HA), .H_BACK_PORCH(HBP), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_START(VS), .V_TOTAL(VT), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .locked(locked), .pixel_valid(pixel_valid),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
      .line_start(line_start), .frame_start(frame_start),
      .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
      .lock_err_cnt(lock_err_cnt)
   );

   // Output monitor: accumulates counts, tasks compare deltas
   int          mon_valid = 0, mon_ls = 0, mon_fs = 0, mon_bad = 0;
   logic [9:0]  mon_last_x = '0, mon_last_y = '0, mon_fs_x = '1, mon_fs_y = '1;
   logic [11:0] mon_fs_rgb = '0;

   always @(negedge clk) begin
      logic [11:0] exp_rgb;
      exp_rgb = {6'(pixel_y + 10'(VS)), 6'(pixel_x + 10'(HBP + 2))};
      if (pixel_valid === 1'b1) begin
         mon_valid  = mon_valid + 1;
         mon_last_x = pixel_x;
         mon_last_y = pixel_y;
         if (pixel_rgb !== exp_rgb) mon_bad = mon_bad + 1;
      end else if (pixel_valid === 1'b0 && pixel_rgb !== 12'h000) begin
         mon_bad = mon_bad + 1;
      end
      if (line_start === 1'b1) mon_ls = mon_ls + 1;
      if (frame_start === 1'b1) begin
         mon_fs     = mon_fs + 1;
         mon_fs_x   = pixel_x;
         mon_fs_y   = pixel_y;
         mon_fs_rgb = pixel_rgb;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_cycle(input logic hs, input logic vs, input logic [11:0] rgb);
      vga_hsync = hs;
      vga_vsync = vs;
      {vga_r, vga_g, vga_b} = rgb;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_span(input int len, input logic vs_low, input int l,
                             input int c0, input int c1);
      for (int c = c0; c < c1 && c < len; c++)
         drive_cycle((c >= 2), ~vs_low, {6'(l), 6'(c)});
   endtask

   task automatic drive_line(input int len, input logic vs_low, input int l);
      drive_span(len, vs_low, l, 0, len);
   endtask

   task automatic drive_frame_part(input int n, input int l0, input int l1, input int short_idx);
      for (int l = l0; l < l1; l++)
         drive_line((l == short_idx) ? HT - 1 : HT, (l == n - 1), l);
   endtask

   task automatic drive_frame(input int n, input int short_idx);
      drive_frame_part(n, 0, n, short_idx);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({locked, pixel_valid, line_start, frame_start} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {locked, pixel_valid, line_start, frame_start});
      end
      checks++;
      if ({pixel_x, pixel_y, pixel_rgb} !== 32'd0) begin
         errors++;
         $display("FAIL reset_pixel: x=%0d y=%0d rgb=%h expected all 0", pixel_x, pixel_y, pixel_rgb);
      end
      checks++;
      if ({h_total_meas, v_total_meas} !== 22'd0) begin
         errors++;
         $display("FAIL reset_meas: h=%0d v=%0d expected 0 0", h_total_meas, v_total_meas);
      end
      checks++;
      if (lock_err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_err_cnt: got %0d expected 0", lock_err_cnt);
      end
   endtask

   task automatic test_lock();
      drive_line(HT, 1'b1, VT - 1);      // preamble: first h-rise and vsync low
      drive_frame(VT, -1);               // measurement frame
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL lock_measuring: locked=%b expected 0", locked); end
      drive_span(HT, 1'b0, 0, 0, 3);     // up to the qualifying vpos reset
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b expected 0", locked); end
      drive_span(HT, 1'b0, 0, 3, 4);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: locked=%b expected 1", locked); end
      checks++;
      if (h_total_meas !== 11'(HT)) begin errors++; $display("FAIL lock_h_meas: got %0d expected %0d", h_total_meas, HT); end
      checks++;
      if (v_total_meas !== 11'(VT)) begin errors++; $display("FAIL lock_v_meas: got %0d expected %0d", v_total_meas, VT); end
      checks++;
      if (lock_err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err_cnt: got %0d expected 0", lock_err_cnt); end
      drive_span(HT, 1'b0, 0, 4, HT);
      drive_frame_part(VT, 1, VT, -1);
      $display("transaction lock: locked=%b h=%0d v=%0d", locked, h_total_meas, v_total_meas);
   endtask

   task automatic test_pixels();
      int v0, ls0, fs0, bad0;
      v0 = mon_valid; ls0 = mon_ls; fs0 = mon_fs; bad0 = mon_bad;
      drive_frame(VT, -1);
      checks++;
      if (mon_valid - v0 !== HA * VA) begin errors++; $display("FAIL pix_valid_count: got %0d expected %0d", mon_valid - v0, HA * VA); end
      checks++;
      if (mon_ls - ls0 !== VA) begin errors++; $display("FAIL pix_line_starts: got %0d expected %0d", mon_ls - ls0, VA); end
      checks++;
      if (mon_fs - fs0 !== 1) begin errors++; $display("FAIL pix_frame_starts: got %0d expected 1", mon_fs - fs0); end
      checks++;
      if (mon_bad - bad0 !== 0) begin errors++; $display("FAIL pix_rgb: %0d bad samples expected 0", mon_bad - bad0); end
      checks++;
      if ({mon_fs_x, mon_fs_y} !== 20'd0) begin errors++; $display("FAIL pix_first_xy: got %0d,%0d expected 0,0", mon_fs_x, mon_fs_y); end
      checks++;
      if (mon_fs_rgb !== 12'h085) begin errors++; $display("FAIL pix_first_rgb: got %h expected 085", mon_fs_rgb); end
      checks++;
      if (mon_last_x !== 10'(HA - 1) || mon_last_y !== 10'(VA - 1)) begin
         errors++;
         $display("FAIL pix_last_xy: got %0d,%0d expected %0d,%0d", mon_last_x, mon_last_y, HA - 1, VA - 1);
      end
      $display("transaction pixels: valid=%0d line_starts=%0d", mon_valid - v0, mon_ls - ls0);
   endtask

   task automatic test_short_line();
      drive_frame_part(VT, 0, 6, 5);     // line 5 is one clock short
      drive_span(HT, 1'b0, 6, 0, 3);     // h-rise that measures the short line
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL short_before: locked=%b expected 1", locked); end
      drive_span(HT, 1'b0, 6, 3, 4);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL short_drop: locked=%b expected 0", locked); end
      checks++;
      if (lock_err_cnt !== 8'd1) begin errors++; $display("FAIL short_err_cnt: got %0d expected 1", lock_err_cnt); end
      checks++;
      if (h_total_meas !== 11'(HT - 1)) begin errors++; $display("FAIL short_h_meas: got %0d expected %0d", h_total_meas, HT - 1); end
      drive_span(HT, 1'b0, 6, 4, HT);
      drive_frame_part(VT, 7, VT, -1);
      drive_frame(VT, -1);               // first clean vsync rise: measure
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL short_relock_early: locked=%b expected 0", locked); end
      drive_line(HT, 1'b0, 0);           // second clean vsync rise: lock
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL short_relock: locked=%b expected 1", locked); end
      drive_frame_part(VT, 1, VT, -1);
      $display("transaction short_line: locked=%b lock_err_cnt=%0d", locked, lock_err_cnt);
   endtask

   task automatic test_timeout();
      int v0;
      drive_frame_part(VT, 0, 4, -1);    // last h-rise is line 3, cycle 2
      v0 = mon_valid;
      for (int j = 0; j < 19; j++) drive_cycle(1'b1, 1'b1, 12'h000);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL timeout_before: locked=%b expected 1", locked); end
      drive_cycle(1'b1, 1'b1, 12'h000);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL timeout_drop: locked=%b expected 0", locked); end
      checks++;
      if (lock_err_cnt !== 8'd2) begin errors++; $display("FAIL timeout_err_cnt: got %0d expected 2", lock_err_cnt); end
      for (int j = 0; j < 20; j++) drive_cycle(1'b1, 1'b1, 12'hFFF);
      checks++;
      if (mon_valid - v0 !== 0) begin errors++; $display("FAIL timeout_valid: got %0d valid cycles expected 0", mon_valid - v0); end
      $display("transaction timeout: locked=%b lock_err_cnt=%0d", locked, lock_err_cnt);
   endtask

   task automatic test_short_frame();
      drive_line(HT, 1'b1, VT - 1);      // vsync low before the next frame
      drive_frame(VT - 1, -1);           // MEASURE entered; this frame is 9 lines
      drive_line(HT, 1'b0, 0);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL frame9_nolock: locked=%b expected 0", locked); end
      checks++;
      if (v_total_meas !== 11'(VT - 1)) begin errors++; $display("FAIL frame9_v_meas: got %0d expected %0d", v_total_meas, VT - 1); end
      drive_frame_part(VT, 1, VT, -1);
      drive_line(HT, 1'b0, 0);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL frame10_lock: locked=%b expected 1", locked); end
      checks++;
      if (v_total_meas !== 11'(VT)) begin errors++; $display("FAIL frame10_v_meas: got %0d expected %0d", v_total_meas, VT); end
      $display("transaction short_frame: locked=%b v=%0d", locked, v_total_meas);
   endtask

   task automatic test_reset_mid();
      drive_frame_part(VT, 1, 3, -1);
      drive_span(HT, 1'b0, 3, 0, 9);     // mid active line
      checks++;
      if (pixel_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: pixel_valid=%b expected 1", pixel_valid); end
      rst = 1'b1;
      #1;
      checks++;
      if ({locked, pixel_valid, line_start, frame_start, pixel_x, pixel_y, pixel_rgb} !== 36'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: locked=%b valid=%b x=%0d y=%0d rgb=%h expected all 0",
                  locked, pixel_valid, pixel_x, pixel_y, pixel_rgb);
      end
      checks++;
      if (lock_err_cnt !== 8'd0 || h_total_meas !== 11'd0) begin
         errors++;
         $display("FAIL mid_reset_counters: err=%0d h=%0d expected 0 0", lock_err_cnt, h_total_meas);
      end
      drive_cycle(1'b1, 1'b1, 12'h000);
      drive_cycle(1'b1, 1'b1, 12'h000);
      rst = 1'b0;
      drive_line(HT, 1'b1, VT - 1);
      drive_frame(VT, -1);
      drive_line(HT, 1'b0, 0);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL mid_relock: locked=%b expected 1", locked); end
      checks++;
      if (lock_err_cnt !== 8'd0) begin errors++; $display("FAIL mid_relock_err: got %0d expected 0", lock_err_cnt); end
      $display("transaction reset_mid: locked=%b lock_err_cnt=%0d", locked, lock_err_cnt);
   endtask

   initial begin
      rst       = 1'b1;
      vga_hsync = 1'b1;
      vga_vsync = 1'b1;
      {vga_r, vga_g, vga_b} = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      $display("transaction reset: locked=%b valid=%b", locked, pixel_valid);
      rst = 1'b0;
      test_lock();
      test_pixels();
      test_short_line();
      test_timeout();
      test_short_frame();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
